// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-byte handshake bundle for uart_rx_core
// The master side drives the byte and its valid flag; the slave side accepts with m_ready.
interface uart_rx_core_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling 8N1 UART receiver with byte handshake
// Mid-bit sampling on a divided tick; one-deep output holding register with overrun detection.
module uart_rx_core #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  uart_rx_core_if.master        m,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int HALF  = OVERSAMPLE / 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_core: CLK_HZ too low for BAUD*OVERSAMPLE");
    end
  endgenerate

  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [SC_W-1:0]  sample_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             done;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));
  assign busy = (state != S_IDLE);

  // rx_d is the previous rx_s, used only for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Held at zero in IDLE so every frame starts its tick phase fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_d && !rx_s) begin
            state      <= S_START;
            sample_cnt <= '0;
            bit_idx    <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (sample_cnt == SC_W'(HALF - 1)) begin
              sample_cnt <= '0;
              state      <= rx_s ? S_IDLE : S_DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (sample_cnt == SC_W'(OVERSAMPLE - 1)) begin
              sample_cnt <= '0;
              shift      <= {rx_s, shift[7:1]};
              bit_idx    <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= S_STOP;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (sample_cnt == SC_W'(OVERSAMPLE - 1)) begin
              sample_cnt <= '0;
              if (rx_s) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A completion may replace the held byte only if the slot is empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m.m_data  <= 8'h00;
      m.m_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!m.m_valid || m.m_ready) begin
          m.m_data  <= shift;
          m.m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end

endmodule
